// File: rtl/dual_pkg.sv
// Shared definitions for the dual-rail client port: rail pair type, FSM
// states, boolean macros and the 2-phase encode/decode helpers.
`ifndef DUAL_PKG_DEFS
`define DUAL_PKG_DEFS
`define SIZE 8
`define TRUE 1'b1
`define FALSE 1'b0
`endif

package dual_pkg;

   // One dual-rail bit: t rail toggles for a 1, f rail toggles for a 0.
   typedef struct packed {
      logic t;
      logic f;
   } Dual;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // Encode one bit of a new token by toggling the rail selected by b.
   function automatic Dual dual_toggle(input Dual d, input logic b);
      Dual r;
      r = d;
      if (b) r.t = ~d.t;
      else   r.f = ~d.f;
      return r;
   endfunction

   // A bit is complete once either rail differs from the snapshot.
   function automatic logic dual_changed(input Dual cur, input Dual prev);
      return (cur.t != prev.t) || (cur.f != prev.f);
   endfunction

   // Decoded value of a completed bit: the t rail moved.
   function automatic logic dual_t_changed(input Dual cur, input Dual prev);
      return cur.t != prev.t;
   endfunction

   // Protocol violation: both rails of one bit moved in the same token.
   function automatic logic dual_both_changed(input Dual cur, input Dual prev);
      return (cur.t != prev.t) && (cur.f != prev.f);
   endfunction

endpackage

// File: rtl/dual_sync.sv
// Two-flop synchronizer bringing the asynchronous dual-rail return channel
// into the clk domain. Synchronous active-low reset clears both stages.
module dual_sync
   import dual_pkg::*;
#(
   parameter int WIDTH = `SIZE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  Dual [WIDTH-1:0]  d,
   output Dual [WIDTH-1:0]  q
);

   Dual [WIDTH-1:0] meta_q, meta_d;
   Dual [WIDTH-1:0] sync_q, sync_d;

   // Next-stage values: shift the channel one flop further each cycle.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Synchronizer register chain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dual_client_port.sv
// Synchronous valid/ready client adapter onto one dual-rail bus user channel.
// Requests become 2-phase dual-rail tokens on user_input; completed tokens on
// user_output are decoded into a held synchronous response.
module dual_client_port
   import dual_pkg::*;
#(
   parameter int WIDTH   = `SIZE,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_data,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_timeout,
   output logic             resp_error,
   output Dual [WIDTH-1:0]  user_input,
   input  Dual [WIDTH-1:0]  user_output
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   Dual [WIDTH-1:0]  rx;
   Dual [WIDTH-1:0]  rx_last_q, rx_last_d;
   Dual [WIDTH-1:0]  prev_rx_q, prev_rx_d;
   Dual [WIDTH-1:0]  ui_q, ui_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic [WIDTH-1:0] resp_data_q, resp_data_d;
   logic             resp_timeout_q, resp_timeout_d;
   logic             resp_error_q, resp_error_d;

   logic             all_changed;
   logic             complete;
   logic [WIDTH-1:0] dec_data;
   logic             dec_err;

   dual_sync #(.WIDTH(WIDTH)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (user_output),
      .q       (rx)
   );

   // Completion detection and decode of the synchronized return token.
   always_comb begin
      all_changed = `TRUE;
      dec_data    = '0;
      dec_err     = `FALSE;
      rx_last_d   = rx;
      for (int i = 0; i < WIDTH; i++) begin
         if (!dual_changed(rx[i], prev_rx_q[i])) all_changed = `FALSE;
         dec_data[i] = dual_t_changed(rx[i], prev_rx_q[i]);
         if (dual_both_changed(rx[i], prev_rx_q[i])) dec_err = `TRUE;
      end
      // Stability against the previous cycle filters out rails still settling
      // through the synchronizer.
      complete = all_changed && (rx == rx_last_q);
   end

   // FSM next state, timeout counter and response datapath.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      prev_rx_d      = prev_rx_q;
      ui_d           = ui_q;
      resp_data_d    = resp_data_q;
      resp_timeout_d = resp_timeout_q;
      resp_error_d   = resp_error_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               for (int i = 0; i < WIDTH; i++) begin
                  ui_d[i] = dual_toggle(ui_q[i], req_data[i]);
               end
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Completion takes priority over a coincident timeout.
            if (complete) begin
               resp_data_d    = dec_data;
               resp_error_d   = dec_err;
               resp_timeout_d = `FALSE;
               prev_rx_d      = rx;
               state_d        = ST_RESP;
            end else if (cnt_q >= CNT_LAST) begin
               resp_data_d    = '0;
               resp_error_d   = `FALSE;
               resp_timeout_d = `TRUE;
               state_d        = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               resp_timeout_d = `FALSE;
               resp_error_d   = `FALSE;
               // A timed-out token is still owed by the bus; absorb it first.
               state_d = resp_timeout_q ? ST_DRAIN : ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (complete) begin
               prev_rx_d = rx;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Handshake outputs are registered from the next state so they carry no
      // combinational path from any input.
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   // State and datapath registers; prev_rx tracks the channel during reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         prev_rx_q      <= rx;
         rx_last_q      <= rx;
         ui_q           <= '0;
         req_ready_q    <= `FALSE;
         resp_valid_q   <= `FALSE;
         resp_data_q    <= '0;
         resp_timeout_q <= `FALSE;
         resp_error_q   <= `FALSE;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         prev_rx_q      <= prev_rx_d;
         rx_last_q      <= rx_last_d;
         ui_q           <= ui_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_data_q    <= resp_data_d;
         resp_timeout_q <= resp_timeout_d;
         resp_error_q   <= resp_error_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_timeout = resp_timeout_q;
   assign resp_error   = resp_error_q;
   assign user_input   = ui_q;

endmodule

// File: tb/tb_dual_client_port.sv
// Bench for dual_client_port: plays the bus side of the dual-rail channel,
// keeps a transaction-level expectation of every output and compares it on
// each falling edge.
module tb_dual_client_port;
   import dual_pkg::*;

   localparam int W  = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_data;
   logic          resp_timeout;
   logic          resp_error;
   Dual [W-1:0]   user_input;
   Dual [W-1:0]   user_output;

   // bus-side rails driven by the bench
   logic [W-1:0]  uo_t, uo_f;
   // expected DUT outputs
   logic [W-1:0]  ui_t, ui_f;
   logic          exp_ready, exp_valid, exp_to, exp_err;
   logic [W-1:0]  exp_data;
   bit            chk_en;
   // snapshots for literal checks
   logic [W-1:0]  snap_dt, snap_df, snap_data;
   logic          snap_to, snap_err;

   int n_tests = 0;
   int n_fail  = 0;

   dual_client_port #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_data     (req_data),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_timeout (resp_timeout),
      .resp_error   (resp_error),
      .user_input   (user_input),
      .user_output  (user_output)
   );

   always #5 clk = ~clk;

   always_comb begin
      user_output = '0;
      for (int i = 0; i < W; i++) begin
         user_output[i].t = uo_t[i];
         user_output[i].f = uo_f[i];
      end
   end

   function automatic logic [W-1:0] rails_t(input Dual [W-1:0] d);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = d[i].t;
      return r;
   endfunction

   function automatic logic [W-1:0] rails_f(input Dual [W-1:0] d);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = d[i].f;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the expected outputs.
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
         check("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
         check("resp_timeout", {31'b0, resp_timeout}, {31'b0, exp_to});
         check("resp_error", {31'b0, resp_error}, {31'b0, exp_err});
         check("ui_t", {24'b0, rails_t(user_input)}, {24'b0, ui_t});
         check("ui_f", {24'b0, rails_f(user_input)}, {24'b0, ui_f});
         if (exp_valid) check("resp_data", {24'b0, resp_data}, {24'b0, exp_data});
      end
   end

   // One complete request/response exchange. skew<0 returns bit i on cycle i;
   // otherwise each bit lands after a random 0..skew cycle delay.
   task automatic do_txn(input logic [W-1:0] req, input logic [W-1:0] rsp,
                         input logic [W-1:0] errm, input int skew, input bit tmo,
                         input logic [W-1:0] late, input int bp);
      int d [W];
      int last;
      logic [W-1:0] t0, f0;
      t0 = rails_t(user_input);
      f0 = rails_f(user_input);
      req_valid = 1'b1;
      req_data  = req;
      tick();
      ui_t ^= req;
      ui_f ^= ~req;
      exp_ready = 1'b0;
      snap_dt = rails_t(user_input) ^ t0;
      snap_df = rails_f(user_input) ^ f0;
      req_valid = 1'b0;
      req_data  = W'($urandom);
      if (tmo) begin
         repeat (TO) tick();
         exp_valid = 1'b1; exp_to = 1'b1; exp_err = 1'b0; exp_data = '0;
      end else begin
         last = 0;
         for (int i = 0; i < W; i++) begin
            d[i] = (skew < 0) ? i : int'($urandom_range(skew, 0));
            if (d[i] > last) last = d[i];
         end
         for (int j = 0; j < last + 4; j++) begin
            for (int i = 0; i < W; i++) begin
               if (d[i] == j) begin
                  if (rsp[i] || errm[i])  uo_t[i] = ~uo_t[i];
                  if (!rsp[i] || errm[i]) uo_f[i] = ~uo_f[i];
               end
            end
            tick();
         end
         exp_valid = 1'b1; exp_to = 1'b0; exp_err = |errm; exp_data = rsp | errm;
      end
      snap_data = resp_data;
      snap_to   = resp_timeout;
      snap_err  = resp_error;
      repeat (bp) tick();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      exp_valid = 1'b0; exp_to = 1'b0; exp_err = 1'b0;
      if (!tmo) begin
         exp_ready = 1'b1;
      end else begin
         repeat ($urandom_range(3, 0)) tick();
         uo_t ^= late;
         uo_f ^= ~late;
         repeat (4) tick();
         exp_ready = 1'b1;
      end
   endtask

   initial begin
      reset_n = 1'b0; req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
      uo_t = '0; uo_f = '0; ui_t = '0; ui_f = '0;
      exp_ready = 1'b0; exp_valid = 1'b0; exp_to = 1'b0; exp_err = 1'b0; exp_data = '0;
      chk_en = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
      exp_ready = 1'b1;
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_valid", {31'b0, resp_valid}, 32'd0);

      // reset while waiting, with a token already in flight
      req_valid = 1'b1; req_data = 8'h33;
      tick();
      ui_t ^= 8'h33; ui_f ^= ~8'h33; exp_ready = 1'b0;
      req_valid = 1'b0;
      uo_t ^= 8'h77; uo_f ^= ~8'h77;
      tick();
      reset_n = 1'b0; uo_t = '0; uo_f = '0;
      tick();
      ui_t = '0; ui_f = '0;
      tick();
      reset_n = 1'b1;
      tick();
      exp_ready = 1'b1;
      check("rst2_ready", {31'b0, req_ready}, 32'd1);
      check("rst2_rails", {16'b0, rails_t(user_input), rails_f(user_input)}, 32'd0);
      repeat (8) tick();

      // basic request
      do_txn(8'hA5, 8'h3C, 8'h00, 0, 1'b0, 8'h00, 0);
      check("basic_t_rails", {24'b0, snap_dt}, 32'hA5);
      check("basic_f_rails", {24'b0, snap_df}, 32'h5A);
      check("basic_data", {24'b0, snap_data}, 32'h3C);

      // skewed response, one bit per cycle
      do_txn(8'h0F, 8'hFF, 8'h00, -1, 1'b0, 8'h00, 0);
      check("skew_data", {24'b0, snap_data}, 32'hFF);

      // backpressure followed by an immediate second request
      do_txn(8'h96, 8'hC3, 8'h00, 2, 1'b0, 8'h00, 5);
      do_txn(8'h5A, 8'h81, 8'h00, 0, 1'b0, 8'h00, 0);
      check("b2b_t_rails", {24'b0, snap_dt}, 32'h5A);
      check("b2b_data", {24'b0, snap_data}, 32'h81);

      // timeout and drain of the late token
      do_txn(8'h42, 8'h00, 8'h00, 0, 1'b1, 8'h11, 2);
      check("tmo_flag", {31'b0, snap_to}, 32'd1);
      check("tmo_data", {24'b0, snap_data}, 32'h00);

      // both rails of bit 3
      do_txn(8'h24, 8'h08, 8'h08, 0, 1'b0, 8'h00, 1);
      check("err_flag", {31'b0, snap_err}, 32'd1);
      check("err_data", {24'b0, snap_data}, 32'h08);

      // randomized traffic
      for (int k = 0; k < 40; k++) begin
         int r;
         logic [W-1:0] em;
         r  = int'($urandom_range(99, 0));
         em = (r >= 15 && r < 30) ? (W'(1) << $urandom_range(W - 1, 0)) : '0;
         do_txn(W'($urandom), W'($urandom), em, int'($urandom_range(3, 0)),
                r < 15, W'($urandom), int'($urandom_range(4, 0)));
         repeat ($urandom_range(2, 0)) tick();
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
